// File: rtl/core_defs.sv
// Shared core definitions: load byte-lane encodings and default widths
// used by the load-return path and the uncached-load path.
package core_defs;

  localparam logic [3:0] LS_B = 4'b0001;
  localparam logic [3:0] LS_H = 4'b0011;
  localparam logic [3:0] LS_W = 4'b1111;

  localparam int REG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shifts the raw bus word down to the
// addressed byte, masks to the access size and sign/zero-extends.
module load_align
  import core_defs::*;
(
  input  logic [3:0]  lsV,
  input  logic [1:0]  addr,
  input  logic        loadX,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    result  = '0;

    result[7:0] = lsV[0] ? shifted[7:0] : 8'h00;

    if (lsV[1])
      result[15:8] = shifted[15:8];
    else if (lsV[0] && loadX)
      result[15:8] = {8{shifted[7]}};

    // Upper half takes the data only for a full word; otherwise it extends
    // from the sign bit of the widest lane actually loaded.
    if (lsV[3] && lsV[2])
      result[31:16] = shifted[31:16];
    else if (lsV[1] && loadX)
      result[31:16] = {16{shifted[15]}};
    else if (lsV[0] && loadX)
      result[31:16] = {16{shifted[7]}};
  end

endmodule

// File: rtl/wb_load_queue.sv
// Load-return / writeback unit: in-order queue of outstanding load
// descriptors, paired with returning read data to produce GPR writes.
module wb_load_queue
  import core_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_lsV,
  input  logic [1:0]               req_addr,
  input  logic                     req_loadX,
  input  logic [REG_W-1:0]         req_wreg,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     flush,
  output logic                     wb_valid,
  output logic [REG_W-1:0]         wb_wreg,
  output logic [DATA_W-1:0]        wb_wdata,
  input  logic [REG_W-1:0]         query_reg,
  output logic                     query_hit,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [3:0]       lsV;
    logic [1:0]       addr;
    logic             loadX;
    logic [REG_W-1:0] wreg;
  } desc_t;

  desc_t            desc_mem [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [DEPTH-1:0] live_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  desc_t             head;
  logic [DATA_W-1:0] head_data;
  logic              head_write;
  logic [DEPTH-1:0]  hit_vec;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign rsp_ready = !empty;
  assign push      = req_valid && !full;
  assign pop       = rsp_valid && !empty;
  assign pending   = count_reg;
  assign busy      = !empty || wb_valid;

  assign head = desc_mem[rd_ptr_reg];
  // A pop coinciding with a flush belongs to a killed load.
  assign head_write = live_reg[rd_ptr_reg] && !flush && (head.wreg != '0);

  load_align u_align (
    .lsV    (head.lsV),
    .addr   (head.addr),
    .loadX  (head.loadX),
    .rdata  (rsp_rdata),
    .result (head_data)
  );

  always_ff @(posedge clk) begin
    if (push)
      desc_mem[wr_ptr_reg] <= {req_lsV, req_addr, req_loadX, req_wreg};
  end

  // Live bits are cleared on pop, so a set bit always marks an occupied slot.
  // A push in the flush cycle is applied last and therefore survives.
  always_comb begin
    live_next = flush ? '0 : live_reg;
    if (pop)
      live_next[rd_ptr_reg] = 1'b0;
    if (push)
      live_next[wr_ptr_reg] = 1'b1;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit_vec[gi] = live_reg[gi] && (desc_mem[gi].wreg == query_reg);
  end

  assign query_hit = (query_reg != '0) && (|hit_vec);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      wb_valid   <= 1'b0;
      wb_wreg    <= '0;
      wb_wdata   <= '0;
    end else begin
      live_reg <= live_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
      wb_valid <= pop && head_write;
      if (pop) begin
        wb_wreg  <= head.wreg;
        wb_wdata <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_load_queue.sv
// Self-checking bench for wb_load_queue: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_wb_load_queue;
  import core_defs::*;

  localparam int DEPTH = 4;
  localparam int REG_W = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_lsV;
  logic [1:0]        req_addr;
  logic              req_loadX;
  logic [REG_W-1:0]  req_wreg;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              flush;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_wreg;
  logic [31:0]       wb_wdata;
  logic [REG_W-1:0]  query_reg;
  logic              query_hit;
  logic [2:0]        pending;
  logic              busy;

  wb_load_queue #(.DEPTH(DEPTH), .REG_W(REG_W), .DATA_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lsV   (req_lsV),
    .req_addr  (req_addr),
    .req_loadX (req_loadX),
    .req_wreg  (req_wreg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .query_reg (query_reg),
    .query_hit (query_hit),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rv;
    logic [3:0]       lsv;
    logic [1:0]       addr;
    logic             lx;
    logic [REG_W-1:0] wreg;
    logic             sv;
    logic [31:0]      rdata;
    logic             fl;
    logic [REG_W-1:0] q;
  } stim_t;

  typedef struct {
    stim_t            s;
    logic             ewv;
    logic [REG_W-1:0] ewreg;
    logic [31:0]      ewdata;
    logic [2:0]       epend;
    logic             ehit;
  } vec_t;

  typedef struct {
    logic [3:0]       lsv;
    logic [1:0]       addr;
    logic             lx;
    logic [REG_W-1:0] wreg;
    logic             live;
  } mdesc_t;

  int n_vec  = 0;
  int n_miss = 0;

  mdesc_t           mq[$];
  logic             m_wv;
  logic [REG_W-1:0] m_wreg;
  logic [31:0]      m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference alignment: take the access size in bytes from the lane mask,
  // shift the word down by the byte offset, keep that many bytes, extend.
  function automatic logic [31:0] ref_align(input logic [3:0] lsv, input logic [1:0] a,
                                            input logic lx, input logic [31:0] rd);
    int          nbytes;
    logic [31:0] s;
    logic [31:0] m;
    logic [31:0] v;
    nbytes = (lsv == LS_W) ? 4 : (lsv == LS_H) ? 2 : 1;
    s = rd >> (8 * int'(a));
    m = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    v = s & m;
    if (lx && nbytes < 4 && s[8 * nbytes - 1])
      v = v | ~m;
    return v;
  endfunction

  function automatic stim_t st(input logic rv, input logic [3:0] lsv, input logic [1:0] a,
                               input logic lx, input logic [REG_W-1:0] w, input logic sv,
                               input logic [31:0] rd, input logic fl, input logic [REG_W-1:0] q);
    stim_t r;
    r.rv = rv; r.lsv = lsv; r.addr = a; r.lx = lx; r.wreg = w;
    r.sv = sv; r.rdata = rd; r.fl = fl; r.q = q;
    return r;
  endfunction

  function automatic stim_t idle(input logic [REG_W-1:0] q);
    return st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, q);
  endfunction

  function automatic stim_t rsp(input logic [31:0] rd);
    return st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b1, rd, 1'b0, 5'd0);
  endfunction

  function automatic stim_t lw(input logic [REG_W-1:0] w);
    return st(1'b1, LS_W, 2'd0, 1'b0, w, 1'b0, 32'd0, 1'b0, 5'd0);
  endfunction

  function automatic logic model_hit(input logic [REG_W-1:0] q);
    if (q == '0) return 1'b0;
    foreach (mq[i])
      if (mq[i].live && mq[i].wreg == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wv = 1'b0;
    m_wreg = '0;
    m_wdata = '0;
  endtask

  task automatic model_check(input logic [REG_W-1:0] q);
    chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("rsp_ready", 32'(rsp_ready), 32'(mq.size() > 0));
    chk("pending",   32'(pending),   32'(mq.size()));
    chk("query_hit", 32'(query_hit), 32'(model_hit(q)));
    chk("busy",      32'(busy),      32'((mq.size() > 0) || m_wv));
    chk("wb_valid",  32'(wb_valid),  32'(m_wv));
    chk("wb_wreg",   32'(wb_wreg),   32'(m_wreg));
    chk("wb_wdata",  wb_wdata,       m_wdata);
  endtask

  task automatic model_update(input stim_t s);
    mdesc_t h;
    mdesc_t d;
    logic   do_push;
    do_push = s.rv && (mq.size() < DEPTH);
    if (s.sv && mq.size() > 0) begin
      h = mq.pop_front();
      m_wv    = h.live && !s.fl && (h.wreg != '0);
      m_wreg  = h.wreg;
      m_wdata = ref_align(h.lsv, h.addr, h.lx, s.rdata);
      $display("pop: r%0d data=0x%08h write=%0b", h.wreg, m_wdata, m_wv);
    end else begin
      m_wv = 1'b0;
    end
    if (s.fl)
      foreach (mq[i]) mq[i].live = 1'b0;
    if (do_push) begin
      d.lsv = s.lsv; d.addr = s.addr; d.lx = s.lx; d.wreg = s.wreg; d.live = 1'b1;
      mq.push_back(d);
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    req_valid = s.rv;  req_lsV = s.lsv;  req_addr = s.addr;  req_loadX = s.lx;
    req_wreg  = s.wreg; rsp_valid = s.sv; rsp_rdata = s.rdata; flush = s.fl;
    query_reg = s.q;
    #1;
    model_check(s.q);
  endtask

  task automatic finish_cycle(input stim_t s);
    @(posedge clk);
    model_update(s);
    #1;
  endtask

  task automatic step(input stim_t s);
    drive(s);
    finish_cycle(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++)
      step(rsp($urandom));
    chk("drained", 32'(pending), 32'd0);
  endtask

  vec_t  tbl[11];
  stim_t rs;

  initial begin
    // Directed table: LB sign-extend, LHU then LW in order, write to r0.
    tbl[0]  = '{st(1'b1, LS_B, 2'd3, 1'b1, 5'd8, 1'b0, 32'd0, 1'b0, 5'd8), 1'b0, 5'd0, 32'h0, 3'd0, 1'b0};
    tbl[1]  = '{st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b1, 32'h80AB_CDEF, 1'b0, 5'd8), 1'b0, 5'd0, 32'h0, 3'd1, 1'b1};
    tbl[2]  = '{idle(5'd8), 1'b1, 5'd8, 32'hFFFF_FF80, 3'd0, 1'b0};
    tbl[3]  = '{st(1'b1, LS_H, 2'd2, 1'b0, 5'd9, 1'b0, 32'd0, 1'b0, 5'd9), 1'b0, 5'd8, 32'hFFFF_FF80, 3'd0, 1'b0};
    tbl[4]  = '{st(1'b1, LS_W, 2'd0, 1'b0, 5'd10, 1'b0, 32'd0, 1'b0, 5'd9), 1'b0, 5'd8, 32'hFFFF_FF80, 3'd1, 1'b1};
    tbl[5]  = '{st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b1, 32'h9234_5678, 1'b0, 5'd10), 1'b0, 5'd8, 32'hFFFF_FF80, 3'd2, 1'b1};
    tbl[6]  = '{st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd9), 1'b1, 5'd9, 32'h0000_9234, 3'd1, 1'b0};
    tbl[7]  = '{idle(5'd10), 1'b1, 5'd10, 32'hDEAD_BEEF, 3'd0, 1'b0};
    tbl[8]  = '{st(1'b1, LS_W, 2'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0), 1'b0, 5'd10, 32'hDEAD_BEEF, 3'd0, 1'b0};
    tbl[9]  = '{st(1'b0, LS_W, 2'd0, 1'b0, 5'd0, 1'b1, 32'h0000_1234, 1'b0, 5'd0), 1'b0, 5'd10, 32'hDEAD_BEEF, 3'd1, 1'b0};
    tbl[10] = '{idle(5'd0), 1'b0, 5'd0, 32'h0000_1234, 3'd0, 1'b0};

    resetn = 1'b0;
    req_valid = 1'b0; req_lsV = LS_W; req_addr = '0; req_loadX = 1'b0; req_wreg = '0;
    rsp_valid = 1'b0; rsp_rdata = '0; flush = 1'b0; query_reg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    chk("reset pending", 32'(pending), 32'd0);
    chk("reset wb_wdata", wb_wdata, 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].s);
      chk($sformatf("tbl%0d wb_valid", i), 32'(wb_valid), 32'(tbl[i].ewv));
      chk($sformatf("tbl%0d wb_wreg", i),  32'(wb_wreg),  32'(tbl[i].ewreg));
      chk($sformatf("tbl%0d wb_wdata", i), wb_wdata,      tbl[i].ewdata);
      chk($sformatf("tbl%0d pending", i),  32'(pending),  32'(tbl[i].epend));
      chk($sformatf("tbl%0d query_hit", i), 32'(query_hit), 32'(tbl[i].ehit));
      finish_cycle(tbl[i].s);
    end

    // Fill to DEPTH, probe every destination, then push+pop at count 3.
    for (int i = 1; i <= DEPTH; i++) step(lw(REG_W'(i)));
    for (int i = 1; i <= DEPTH; i++) begin
      drive(idle(REG_W'(i)));
      chk("full query_hit", 32'(query_hit), 32'd1);
      chk("full req_ready", 32'(req_ready), 32'd0);
      chk("full pending",   32'(pending),   32'd4);
      finish_cycle(idle(REG_W'(i)));
    end
    step(lw(5'd20));
    chk("push while full", 32'(pending), 32'd4);
    step(rsp(32'h1111_1111));
    chk("pop to 3", 32'(pending), 32'd3);
    rs = lw(5'd21);
    rs.sv = 1'b1;
    rs.rdata = 32'h2222_2222;
    step(rs);
    chk("push+pop at 3", 32'(pending), 32'd3);
    drain();

    // Flush with two pending while a post-flush load is pushed.
    step(lw(5'd6));
    step(lw(5'd7));
    rs = st(1'b1, LS_W, 2'd0, 1'b0, 5'd5, 1'b0, 32'd0, 1'b1, 5'd6);
    drive(rs);
    chk("flush-cycle hit r6", 32'(query_hit), 32'd1);
    finish_cycle(rs);
    drive(idle(5'd6));
    chk("killed hit r6", 32'(query_hit), 32'd0);
    finish_cycle(idle(5'd6));
    drive(idle(5'd5));
    chk("post-flush hit r5", 32'(query_hit), 32'd1);
    finish_cycle(idle(5'd5));
    step(rsp(32'h0BAD_0001));
    chk("killed wb 1", 32'(wb_valid), 32'd0);
    step(rsp(32'h0BAD_0002));
    chk("killed wb 2", 32'(wb_valid), 32'd0);
    step(rsp(32'hCAFE_F00D));
    chk("r5 wb_valid", 32'(wb_valid), 32'd1);
    chk("r5 wb_wreg",  32'(wb_wreg),  32'd5);
    chk("r5 wb_wdata", wb_wdata,      32'hCAFE_F00D);

    // Asynchronous reset with three loads pending and a write in flight.
    for (int i = 11; i <= 14; i++) step(lw(REG_W'(i)));
    step(rsp(32'h3333_3333));
    chk("pre-reset wb_valid", 32'(wb_valid), 32'd1);
    chk("pre-reset pending",  32'(pending),  32'd3);
    #2;
    resetn = 1'b0;
    req_valid = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
    #1;
    chk("async pending",   32'(pending),   32'd0);
    chk("async wb_valid",  32'(wb_valid),  32'd0);
    chk("async req_ready", 32'(req_ready), 32'd1);
    chk("async rsp_ready", 32'(rsp_ready), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int pick;
      pick = int'($urandom_range(0, 2));
      rs.rv    = 1'($urandom_range(0, 1));
      rs.lsv   = (pick == 0) ? LS_B : (pick == 1) ? LS_H : LS_W;
      rs.addr  = 2'($urandom_range(0, 3));
      rs.lx    = 1'($urandom_range(0, 1));
      rs.wreg  = REG_W'($urandom_range(0, 7));
      rs.sv    = 1'($urandom_range(0, 1));
      rs.rdata = $urandom;
      rs.fl    = ($urandom_range(0, 15) == 0);
      rs.q     = REG_W'($urandom_range(0, 7));
      step(rs);
    end
    drain();
    step(idle(5'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_load_queue.md
Name: wb_load_queue

Overview:
- Parametrised load-return/writeback unit for the AXI CPU core.
- Decouples load issue from data return, so up to DEPTH loads can be outstanding.
- Per load, records a descriptor: byte-lane valid mask, address low bits, signed flag, destination GPR.
- Pairs returning read data with descriptors in order, then shifts, masks and sign/zero-extends the data and issues a registered GPR write. Also reports RAW hazards against pending loads and discards loads killed by a pipeline flush.

Parameters:
- DEPTH, 4, max outstanding loads; power of 2, >=2.
- REG_W, 5, GPR index width.
- DATA_W, 32, data width; fixed at 32 this generation (lane mask is 4 bits).

Ports:
- clk  input  1  core clock, posedge
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  load issued this cycle
- req_ready  output  1  queue can accept a descriptor; equals !full
- req_lsV  input  4  byte-lane mask: 0001 byte, 0011 half, 1111 word
- req_addr  input  2  address bits [1:0]
- req_loadX  input  1  1 = sign-extend (LB/LH), 0 = zero-extend
- req_wreg  input  REG_W  destination GPR
- rsp_valid  input  1  read data returned
- rsp_ready  output  1  equals !empty
- rsp_rdata  input  32  raw bus word
- flush  input  1  kill all entries currently in queue
- wb_valid  output  1  GPR write strobe
- wb_wreg  output  REG_W  GPR index
- wb_wdata  output  32  aligned/extended load result
- query_reg  input  REG_W  register read by instruction in decode
- query_hit  output  1  live pending load targets query_reg
- pending  output  log2(DEPTH)+1  occupancy count
- busy  output  1  pending != 0 or wb_valid

Behaviour:
- **Reset:** async on resetn low. Pointers, count, live bits, wb_valid, wb_wreg and wb_wdata are all cleared to 0. Responses in flight at reset are not tracked; the system must not deliver them.
- **Storage:** circular FIFO with wr_ptr/rd_ptr (log2 DEPTH bits, wrap naturally) and an explicit count. Each entry holds lsV, addr, loadX, wreg and a live bit.
- **Push:** on req_valid && req_ready. The entry is written with live=1.
- **Pop:** on rsp_valid && rsp_ready. Pushing while full is illegal, and req_ready already blocks it. There is no same-cycle full bypass.
- **Simultaneous push and pop:** count unchanged. Allowed when the queue is empty? No: rsp_ready is 0 when empty, so pop requires a prior entry.
- **Flush:** clears live on every entry present at the start of the cycle.
  - An entry pushed in the same cycle as flush stays live, because it is post-flush.
  - A pop in the same cycle as flush is treated as killed.
  - Killed entries still pop on their response; only the write is suppressed.
- **Result datapath (combinational from head entry + rsp_rdata):**
  - Shift: s = rsp_rdata >> {addr,3'b0}.
  - d[7:0] = lsV[0] ? s[7:0] : 0.
  - d[15:8]: s[15:8] if lsV[1]. Otherwise 8{s[7]} if lsV[0] && loadX. Otherwise 0.
  - d[31:16]: s[31:16] if lsV[3]&&lsV[2]. Otherwise 16{s[15]} if lsV[1]&&loadX. Otherwise 16{s[7]} if lsV[0]&&loadX. Otherwise 0.
  - Other lsV values are masked per these equations, with no further checking.
- **Writeback register, 1-cycle latency:**
  - The cycle after a pop, wb_valid = (popped entry live) && (wreg != 0). wb_wreg and wb_wdata hold the popped values.
  - With no pop, wb_valid = 0 and wb_wreg/wb_wdata hold their previous values.
  - No backpressure: the regfile write port always accepts.
- **query_hit (combinational):** 1 iff query_reg != 0 and some occupied live entry has wreg == query_reg.
  - Excludes the wb register; external forwarding covers it.
  - Includes an entry being popped this cycle, so the result is conservative.
- **Ordering:** AXI read responses are in-order, with a single ID. Out-of-order return is out of scope.

Decomposition:
- Shared package (core_defs): lsV encodings LS_B=4'b0001, LS_H=4'b0011, LS_W=4'b1111, and REG_W default.
- One sub-module: load_align (combinational shift/mask/extend, 32-bit). Reused by the uncached-load path.
- The FIFO is inline in wb_load_queue.

Test Plan:
1. Push LB addr=3 loadX=1 wreg=8, then rsp 0x80AB_CDEF next cycle. Required: wb_valid=1, wreg=8, wdata=0xFFFF_FF80 one cycle after pop.
2. Push LHU addr=2 wreg=9 and LW addr=0 wreg=10. Return 0x9234_5678 then 0xDEAD_BEEF. Required: in-order writes 0x0000_9234 to r9, then 0xDEAD_BEEF to r10.
3. Fill DEPTH=4 without responses. Required: req_ready=0, pending=4, query_hit=1 for each wreg. Then push+pop in the same cycle at count 3: count stays 3.
4. Two pending entries, then flush while simultaneously pushing LW wreg=5. Required: the two responses produce wb_valid=0. The third response writes r5. query_hit(r5)=1 before its return.
5. LW wreg=0, rsp 0x1234. Required: pop occurs, wb_valid=0, query_hit(0)=0.
6. resetn low mid-operation with 3 pending. Required: pending=0, wb_valid=0, req_ready=1 immediately (async), rsp_ready=0.
